// File: rtl/seg7_scan_decoder_if.sv
// Scan bus from a multiplexed 7-segment driver plus the recovered frame results.
// master = driver/observer side, slave = decoder side.
interface seg7_scan_decoder_if;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        frame_valid;
    logic        pattern_err;
    logic [1:0]  err_digit;

    modport master (
        output seg, an, dp,
        input  digits, dp_mask, frame_valid, pattern_err, err_digit
    );

    modport slave (
        input  seg, an, dp,
        output digits, dp_mask, frame_valid, pattern_err, err_digit
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers four BCD digits from a scanned active-low seg/an/dp bus; captures after STABLE_CYCLES identical samples.
// Frame and error pulses appear one edge after the deciding capture; optional hex decode under SEG7_HEX_DECODE_EN.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    seg7_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

    logic [11:0]   samp;
    logic [11:0]   samp_in;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          qual;
    logic          capture;
    logic [4:0]    dec;
    logic [1:0]    idx;
    logic [3:0]    seen;
    logic [3:0]    seen_next;
    logic [15:0]   shadow;
    logic [3:0]    shadow_dp;
    logic          err_pend;
    logic [1:0]    err_idx;
    logic          frame_done;

    function automatic logic anode_ok(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    function automatic logic [1:0] anode_idx(input logic [3:0] a);
        case (a)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Returns {valid, value}; pattern bit 6 is segment a.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0000100: return 5'h19;
`ifdef SEG7_HEX_DECODE_EN
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
`endif
            default:    return 5'h00;
        endcase
    endfunction

    assign samp_in    = {bus.an, bus.seg, bus.dp};
    assign frame_done = (seen == 4'hF);

    always_comb begin
        qual      = anode_ok(bus.an);
        cnt_next  = '0;
        dec       = decode(bus.seg);
        idx       = anode_idx(bus.an);
        if (qual && (samp_in == samp)) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        // cnt_next counts repeats, so it equals STABLE_CYCLES-1 exactly once per dwell.
        capture   = qual && (cnt_next == CNT_CAP);
        seen_next = frame_done ? 4'h0 : seen;
        if (capture && dec[4]) begin
            seen_next[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            samp            <= '0;
            cnt             <= '0;
            seen            <= '0;
            shadow          <= '0;
            shadow_dp       <= '0;
            err_pend        <= 1'b0;
            err_idx         <= '0;
            bus.digits      <= '0;
            bus.dp_mask     <= '0;
            bus.frame_valid <= 1'b0;
            bus.pattern_err <= 1'b0;
            bus.err_digit   <= '0;
        end else begin
            samp     <= samp_in;
            cnt      <= cnt_next;
            seen     <= seen_next;
            err_pend <= capture && !dec[4];
            if (capture && dec[4]) begin
                shadow[{idx, 2'b00} +: 4] <= dec[3:0];
                shadow_dp[idx]            <= ~bus.dp;
            end
            if (capture && !dec[4]) begin
                err_idx <= idx;
            end
            bus.pattern_err <= err_pend;
            if (err_pend) begin
                bus.err_digit <= err_idx;
            end
            bus.frame_valid <= frame_done;
            if (frame_done) begin
                bus.digits  <= shadow;
                bus.dp_mask <= shadow_dp;
            end
        end
    end
endmodule
